// File: rtl/tdm_demux4_if.sv
// ============================================================================
// Module   : tdm_demux4_if
// Brief    : Shared-link input and per-channel output bundle of tdm_demux4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tdm_demux4_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
);
    logic [WIDTH-1:0]     din;
    logic                 din_valid;
    logic                 sync;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     c;
    logic [WIDTH-1:0]     d;
    logic                 frame_valid;
    logic                 locked;
    logic [1:0]           slot;
    logic                 sync_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    // Link side: drives the multiplexed stream, observes the rebuilt frame.
    modport master (
        output din, din_valid, sync,
        input  a, b, c, d, frame_valid, locked, slot, sync_err, err_cnt
    );

    // Demultiplexer side.
    modport slave (
        input  din, din_valid, sync,
        output a, b, c, d, frame_valid, locked, slot, sync_err, err_cnt
    );
endinterface

`default_nettype wire

// File: rtl/tdm_demux4.sv
// ============================================================================
// Module   : tdm_demux4
// Brief    : Rebuilds 4-slot TDM frames into parallel registered channel words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux4 #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  wire              clk,
    input  wire              rst_n,
    tdm_demux4_if.slave      bus
);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_slot;
    logic [1:0]           w_slot_nxt;
    logic [WIDTH-1:0]     r_shadow0;
    logic [WIDTH-1:0]     r_shadow1;
    logic [WIDTH-1:0]     r_shadow2;
    logic [WIDTH-1:0]     w_shadow0_nxt;
    logic [WIDTH-1:0]     w_shadow1_nxt;
    logic [WIDTH-1:0]     w_shadow2_nxt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_c;
    logic [WIDTH-1:0]     r_d;
    logic [WIDTH-1:0]     w_a_nxt;
    logic [WIDTH-1:0]     w_b_nxt;
    logic [WIDTH-1:0]     w_c_nxt;
    logic [WIDTH-1:0]     w_d_nxt;
    logic                 r_frame_valid;
    logic                 w_frame_valid_nxt;
    logic                 r_sync_err;
    logic                 w_sync_err_nxt;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [ERR_CNT_W-1:0] w_err_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_slot        <= 2'd0;
            r_shadow0     <= '0;
            r_shadow1     <= '0;
            r_shadow2     <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_d           <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_slot        <= w_slot_nxt;
            r_shadow0     <= w_shadow0_nxt;
            r_shadow1     <= w_shadow1_nxt;
            r_shadow2     <= w_shadow2_nxt;
            r_a           <= w_a_nxt;
            r_b           <= w_b_nxt;
            r_c           <= w_c_nxt;
            r_d           <= w_d_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_sync_err    <= w_sync_err_nxt;
            r_err_cnt     <= w_err_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_slot_nxt        = r_slot;
        w_shadow0_nxt     = r_shadow0;
        w_shadow1_nxt     = r_shadow1;
        w_shadow2_nxt     = r_shadow2;
        w_a_nxt           = r_a;
        w_b_nxt           = r_b;
        w_c_nxt           = r_c;
        w_d_nxt           = r_d;
        w_frame_valid_nxt = 1'b0;
        w_sync_err_nxt    = 1'b0;

        if (bus.din_valid) begin
            case (r_state)
                HUNT: begin
                    if (bus.sync) begin
                        w_shadow0_nxt = bus.din;
                        w_slot_nxt    = 2'd1;
                        w_state_nxt   = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.sync) begin
                        // A sync anywhere but slot 0 drops the partial frame and restarts it here.
                        w_sync_err_nxt = (r_slot != 2'd0);
                        w_shadow0_nxt  = bus.din;
                        w_slot_nxt     = 2'd1;
                    end else begin
                        case (r_slot)
                            2'd0: begin
                                w_sync_err_nxt = 1'b1;
                                w_state_nxt    = HUNT;
                            end
                            2'd1: begin
                                w_shadow1_nxt = bus.din;
                                w_slot_nxt    = 2'd2;
                            end
                            2'd2: begin
                                w_shadow2_nxt = bus.din;
                                w_slot_nxt    = 2'd3;
                            end
                            default: begin
                                w_a_nxt           = r_shadow0;
                                w_b_nxt           = r_shadow1;
                                w_c_nxt           = r_shadow2;
                                w_d_nxt           = bus.din;
                                w_frame_valid_nxt = 1'b1;
                                w_slot_nxt        = 2'd0;
                            end
                        endcase
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end

        w_err_cnt_nxt = r_err_cnt;
        if (w_sync_err_nxt && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign bus.a           = r_a;
    assign bus.b           = r_b;
    assign bus.c           = r_c;
    assign bus.d           = r_d;
    assign bus.frame_valid = r_frame_valid;
    assign bus.locked      = (r_state == LOCKED);
    assign bus.slot        = r_slot;
    assign bus.sync_err    = r_sync_err;
    assign bus.err_cnt     = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux4.sv
// ============================================================================
// Module   : tb_tdm_demux4
// Brief    : Directed self-checking bench for tdm_demux4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux4;

    localparam int WIDTH     = 8;
    localparam int ERR_CNT_W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    tdm_demux4_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) bus ();

    tdm_demux4 #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one word for one edge; outputs are settled on return.
    task automatic send(input logic [WIDTH-1:0] w, input logic s);
        @(negedge clk);
        bus.din       = w;
        bus.din_valid = 1'b1;
        bus.sync      = s;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.din_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input string tag, input logic [31:0] ea, eb, ec, ed);
        check_eq({tag, "_a"}, 32'(bus.a), ea);
        check_eq({tag, "_b"}, 32'(bus.b), eb);
        check_eq({tag, "_c"}, 32'(bus.c), ec);
        check_eq({tag, "_d"}, 32'(bus.d), ed);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_frame("rst", 0, 0, 0, 0);
        check_eq("rst_locked", 32'(bus.locked), 0);
        check_eq("rst_slot", 32'(bus.slot), 0);
        check_eq("rst_errcnt", 32'(bus.err_cnt), 0);
        check_eq("rst_fv", 32'(bus.frame_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame
        send(8'h11, 1'b1);
        check_eq("t1_locked", 32'(bus.locked), 1);
        check_eq("t1_slot1", 32'(bus.slot), 1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        check_eq("t1_fv_early", 32'(bus.frame_valid), 0);
        send(8'h44, 1'b0);
        check_eq("t1_fv", 32'(bus.frame_valid), 1);
        check_frame("t1", 32'h11, 32'h22, 32'h33, 32'h44);
        check_eq("t1_slot0", 32'(bus.slot), 0);
        check_eq("t1_errcnt", 32'(bus.err_cnt), 0);
        idle(1);
        check_eq("t1_fv_pulse", 32'(bus.frame_valid), 0);

        // Frame with a gap after slot 1
        send(8'h61, 1'b1);
        send(8'h62, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check_eq("t2_gap_slot", 32'(bus.slot), 2);
            check_eq("t2_gap_fv", 32'(bus.frame_valid), 0);
        end
        check_frame("t2_hold", 32'h11, 32'h22, 32'h33, 32'h44);
        send(8'h63, 1'b0);
        check_eq("t2_fv_early", 32'(bus.frame_valid), 0);
        send(8'h64, 1'b0);
        check_eq("t2_fv", 32'(bus.frame_valid), 1);
        check_frame("t2", 32'h61, 32'h62, 32'h63, 32'h64);

        // Early sync resync
        send(8'hA0, 1'b1);
        send(8'hA1, 1'b0);
        send(8'hB0, 1'b1);
        check_eq("t3_err", 32'(bus.sync_err), 1);
        check_eq("t3_errcnt", 32'(bus.err_cnt), 1);
        check_eq("t3_fv", 32'(bus.frame_valid), 0);
        check_eq("t3_slot", 32'(bus.slot), 1);
        check_eq("t3_locked", 32'(bus.locked), 1);
        check_frame("t3_hold", 32'h61, 32'h62, 32'h63, 32'h64);
        send(8'hB1, 1'b0);
        check_eq("t3_err_pulse", 32'(bus.sync_err), 0);
        send(8'hB2, 1'b0);
        send(8'hB3, 1'b0);
        check_eq("t3_fv2", 32'(bus.frame_valid), 1);
        check_frame("t3", 32'hB0, 32'hB1, 32'hB2, 32'hB3);

        // Sync on the slot-3 position is an error
        send(8'hC0, 1'b1);
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b1);
        check_eq("t3b_err", 32'(bus.sync_err), 1);
        check_eq("t3b_fv", 32'(bus.frame_valid), 0);
        check_eq("t3b_errcnt", 32'(bus.err_cnt), 2);
        check_frame("t3b_hold", 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        send(8'hD1, 1'b0);
        send(8'hD2, 1'b0);
        send(8'hD3, 1'b0);
        check_eq("t3b_fv2", 32'(bus.frame_valid), 1);
        check_frame("t3b", 32'hC3, 32'hD1, 32'hD2, 32'hD3);

        // Missing sync drops lock
        send(8'h55, 1'b0);
        check_eq("t4_err", 32'(bus.sync_err), 1);
        check_eq("t4_locked", 32'(bus.locked), 0);
        check_eq("t4_errcnt", 32'(bus.err_cnt), 3);
        check_eq("t4_slot", 32'(bus.slot), 0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        check_eq("t4_hunt_locked", 32'(bus.locked), 0);
        check_eq("t4_hunt_err", 32'(bus.sync_err), 0);
        check_eq("t4_hunt_errcnt", 32'(bus.err_cnt), 3);
        check_eq("t4_hunt_slot", 32'(bus.slot), 0);
        send(8'hE0, 1'b1);
        check_eq("t4_relock", 32'(bus.locked), 1);
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        send(8'hE3, 1'b0);
        check_eq("t4_fv", 32'(bus.frame_valid), 1);
        check_frame("t4", 32'hE0, 32'hE1, 32'hE2, 32'hE3);

        // Asynchronous reset mid-frame
        send(8'hF0, 1'b1);
        send(8'hF1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_frame("t5_rst", 0, 0, 0, 0);
        check_eq("t5_rst_locked", 32'(bus.locked), 0);
        check_eq("t5_rst_slot", 32'(bus.slot), 0);
        check_eq("t5_rst_errcnt", 32'(bus.err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h91, 1'b0);
        check_eq("t5_hunt", 32'(bus.locked), 0);
        send(8'h81, 1'b1);
        send(8'h82, 1'b0);
        send(8'h83, 1'b0);
        send(8'h84, 1'b0);
        check_eq("t5_fv", 32'(bus.frame_valid), 1);
        check_frame("t5", 32'h81, 32'h82, 32'h83, 32'h84);

        // Saturation: first sync is a clean slot-0 capture, each following one is early
        for (int i = 0; i < 261; i++) begin
            send(WIDTH'(i), 1'b1);
            if (i == 254) check_eq("t6_cnt254", 32'(bus.err_cnt), 254);
            if (i == 255) check_eq("t6_cnt255", 32'(bus.err_cnt), 255);
        end
        check_eq("t6_sat", 32'(bus.err_cnt), 255);
        check_eq("t6_err_at_sat", 32'(bus.sync_err), 1);
        check_frame("t6_hold", 32'h81, 32'h82, 32'h83, 32'h84);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receiving end of the 4:1 channel multiplexer.
- Accepts a time-division-multiplexed word stream in which four channels (a, b, c, d) share one data path, one word per slot, with slot 0 tagged by a frame sync.
- Tracks slot position, rebuilds each complete 4-word frame in shadow registers, and presents all four channels together on registered outputs with a one-cycle frame strobe.
- Sits between the serial/shared link and per-channel consumer logic on the FPGA.

Parameters:
WIDTH, 8, bit width of each channel word and of din.
ERR_CNT_W, 8, width of the saturating sync-error counter.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
din  input  WIDTH  multiplexed data word.
din_valid  input  1  din carries a word this cycle.
sync  input  1  marks din as slot 0 (channel a); qualified by din_valid.
a  output  WIDTH  channel 0 word of last complete frame.
b  output  WIDTH  channel 1 word of last complete frame.
c  output  WIDTH  channel 2 word of last complete frame.
d  output  WIDTH  channel 3 word of last complete frame.
frame_valid  output  1  one-cycle pulse: a..d just updated.
locked  output  1  1 while in LOCKED state.
slot  output  2  slot index expected for the next valid word.
sync_err  output  1  one-cycle pulse on framing error.
err_cnt  output  ERR_CNT_W  saturating count of sync_err pulses.

Behaviour:
- Reset (rst_n low, asynchronous):
  - a, b, c, d, shadow registers, slot, err_cnt = 0.
  - frame_valid, sync_err, locked = 0.
  - State = HUNT.
  - Takes effect immediately; any partial frame is discarded.
- Two-state FSM: HUNT, LOCKED. All outputs are registered.
- din_valid = 0: no state, slot or data change. frame_valid and sync_err are 0 that cycle.
- HUNT:
  - Valid words without sync are ignored.
  - din_valid & sync: shadow0 <= din, slot <= 1, go LOCKED.
- LOCKED, din_valid = 1, per expected slot:
  - slot 0, sync = 1: shadow0 <= din, slot <= 1.
  - slot 1 or 2, sync = 0: shadow[slot] <= din, slot <= slot + 1.
  - slot 3, sync = 0: a <= shadow0, b <= shadow1, c <= shadow2, d <= din; frame_valid <= 1; slot <= 0 (wrap).
  - slot != 0, sync = 1 (early sync): sync_err <= 1; partial frame discarded, a..d unchanged; shadow0 <= din, slot <= 1; stay LOCKED (resync).
  - slot 0, sync = 0 (missing sync): sync_err <= 1; word discarded; slot <= 0; go HUNT; locked <= 0.
- Latency: a..d and frame_valid change on the edge that samples the slot-3 word, visible the following cycle. Back-to-back frames give frame_valid every 4 valid words.
- Between frames, a..d hold their last values.
- err_cnt increments on every sync_err. It saturates at all-ones and does not wrap.
- locked reflects the registered state: 1 from the cycle after the sync capture in HUNT.
- Gaps (din_valid low) are allowed at any slot, including between slot 3 and the next sync.
- Simultaneous events: the early-sync rule has priority over normal capture. A sync on the slot-3 position is an error (frame discarded, no frame_valid).

Test Plan:
- Reset then frame 0x11, 0x22 (no sync), 0x33, 0x44 with sync only on 0x11 -> frame_valid one cycle; a = 0x11, b = 0x22, c = 0x33, d = 0x44; locked = 1; slot = 0; err_cnt = 0.
- Same frame with din_valid low for 3 cycles between 0x22 and 0x33 -> identical outputs; frame_valid only after 0x44; slot holds 2 during the gap.
- After a good frame, send 0xA0 (sync), 0xA1, then 0xB0 (sync) -> sync_err pulse; err_cnt = 1; a..d keep old frame; next 0xB1, 0xB2, 0xB3 -> a..d = B0..B3.
- LOCKED at slot 0, send 0x55 without sync -> sync_err; locked = 0 next cycle; following non-sync words ignored; next sync relocks.
- Assert rst_n low mid-frame after 2 words -> all outputs 0 immediately; HUNT; a fresh full frame decodes correctly afterward.
- Force 260 framing errors with ERR_CNT_W = 8 -> err_cnt stops at 255.
